simplecpu_mul: RTL and testbench

Iterative shift-add multiplier for the simplecpu datapath. It is the execute-stage unit behind the multiply instruction that the `test_multiply` firmware exercises. The CPU control unit issues operands with a one-cycle `start` pulse, stalls on `busy`, and captures `product` when `done` pulses. It handles unsigned and two's-complement signed operands with a fixed, data-independent latency.

---
 rtl/simplecpu_mul.sv | 107 ++++++++++
 tb/tb_simplecpu_mul.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/simplecpu_mul.sv
// Iterative shift-add multiplier, unsigned or two's-complement signed.
// The latency is fixed at WIDTH+1 edges from the accepting edge to done, whatever the operand values.
module simplecpu_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               resetb,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_op,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   mcand_reg, mcand_next;
    logic [PW-1:0]   acc_reg, acc_next;
    logic [PW-1:0]   product_reg, product_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            sign_reg, sign_next;
    logic            done_reg, done_next;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PW-1:0]    acc_sum;

    // The magnitude of -2^(WIDTH-1) wraps back to 2^(WIDTH-1).
    // Read as unsigned, that value is exactly the magnitude we need.
    assign a_mag   = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_mag   = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign acc_sum = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            acc_reg     <= '0;
            product_reg <= '0;
            mplier_reg  <= '0;
            count_reg   <= '0;
            sign_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            acc_reg     <= acc_next;
            product_reg <= product_next;
            mplier_reg  <= mplier_next;
            count_reg   <= count_next;
            sign_reg    <= sign_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mcand_next   = mcand_reg;
        acc_next     = acc_reg;
        product_next = product_reg;
        mplier_next  = mplier_reg;
        count_next   = count_reg;
        sign_next    = sign_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = RUN;
                    mcand_next  = {{WIDTH{1'b0}}, a_mag};
                    mplier_next = b_mag;
                    sign_next   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_next    = '0;
                    count_next  = CW'(WIDTH);
                end
            end
            RUN: begin
                acc_next    = acc_sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                count_next  = count_reg - CW'(1);
                // The final iteration's sum goes straight to product.
                // That way done appears on the same edge that retires the last bit.
                if (count_reg == CW'(1)) begin
                    state_next   = IDLE;
                    product_next = sign_reg ? (~acc_sum + PW'(1)) : acc_sum;
                    done_next    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state_reg == RUN);
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_simplecpu_mul.sv
// Testbench for simplecpu_mul at WIDTH=8. It runs table-driven vectors and handshake/reset sequences.
// Expected products pass through a scoreboard queue that the done monitor drains.
module tb_simplecpu_mul;

    logic        clock;
    logic        resetb;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        signed_op;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks;
    int errors;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    simplecpu_mul #(.WIDTH(8)) dut (
        .clock     (clock),
        .resetb    (resetb),
        .start     (start),
        .a         (a),
        .b         (b),
        .signed_op (signed_op),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        int xi;
        int yi;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        return 16'(xi * yi);
    endfunction

    // Scoreboard drain: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (resetb) begin
            if (busy && done) check("busy_done_exclusive", 32'(busy & done), 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    $display("txn product=%04h expected=%04h", product, e);
                    check("product", 32'(product), 32'(e));
                end
            end
        end
    end

    // Drive a request at a negedge so it is sampled on the next rising edge (E0).
    // The task returns at the negedge after E0 with start deasserted.
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                         input logic [15:0] exp, input bit push);
        @(negedge clock);
        a = ta;
        b = tb_v;
        signed_op = ts;
        start = 1'b1;
        if (push) exp_q.push_back(exp);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Starting at the negedge after E0, wait for done, then check latency and the busy length.
    task automatic wait_done(input bit scramble);
        int lat;
        int bcnt;
        lat = 1;
        bcnt = 0;
        while (!done && lat < 50) begin
            if (busy) bcnt++;
            if (scramble) begin
                a = 8'($urandom);
                b = 8'($urandom);
                signed_op = 1'($urandom);
            end
            @(negedge clock);
            lat++;
        end
        check("latency", 32'(lat), 32'd9);
        check("busy_cycles", 32'(bcnt), 32'd8);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        start = 1'b0;
        a = '0;
        b = '0;
        signed_op = 1'b0;
        resetb = 1'b0;

        vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F};
        vecs[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01};
        vecs[2] = '{8'd0,   8'd200, 1'b0, 16'h0000};
        vecs[3] = '{8'hFD,  8'h05,  1'b1, 16'hFFF1};
        vecs[4] = '{8'hFD,  8'h05,  1'b0, 16'h04F1};
        vecs[5] = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vecs[6] = '{8'h80,  8'h7F,  1'b1, 16'hC080};
        vecs[7] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
        vecs[8] = '{8'h7F,  8'h81,  1'b1, 16'hC0FF};
        vecs[9] = '{8'd7,   8'd6,   1'b0, 16'h002A};

        repeat (3) @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        resetb = 1'b1;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 1'b1);
            check("busy_after_e0", 32'(busy), 32'd1);
            wait_done(1'b0);
        end

        // A start at E3 of a running op must be ignored.
        issue(8'd13, 8'd11, 1'b0, 16'h008F, 1'b1);
        repeat (2) @(negedge clock);
        a = 8'd99;
        b = 8'd77;
        signed_op = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        begin
            int lat;
            lat = 4;
            while (!done && lat < 50) begin
                @(negedge clock);
                lat++;
            end
            check("ignored_start_latency", 32'(lat), 32'd9);
        end

        // A start in the done cycle runs back-to-back, and product holds until the new completion.
        a = 8'd7;
        b = 8'd6;
        signed_op = 1'b0;
        start = 1'b1;
        exp_q.push_back(16'h002A);
        @(negedge clock);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_product_held", 32'(product), 32'h008F);
        wait_done(1'b0);

        // Randomise the operand inputs during RUN; the result must follow the operands latched at E0.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            issue(ra, rb, rs, model(ra, rb, rs), 1'b1);
            wait_done(1'b1);
        end

        // Assert reset in the middle of the cycle after E4 of 100x100.
        issue(8'd100, 8'd100, 1'b0, 16'h0000, 1'b0);
        repeat (4) @(negedge clock);
        #2 resetb = 1'b0;
        #1;
        check("midrun_busy", 32'(busy), 32'd0);
        check("midrun_done", 32'(done), 32'd0);
        check("midrun_product", 32'(product), 32'd0);
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clock);
                if (done || busy) seen++;
            end
            check("no_done_after_reset", 32'(seen), 32'd0);
        end
        issue(8'd100, 8'd100, 1'b0, 16'h2710, 1'b1);
        wait_done(1'b0);

        @(negedge clock);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
